// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// The state enum, port indices and default widths live here.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 4;
  localparam int ARB_DATA_W = 4;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake plus memory-side pins of the data-memory arbiter.
// A requester holds req/we/addr/wd stable from assertion through its done cycle.
// done is a single-cycle pulse. A req still high in the cycle after done counts as a new request.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) ();

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wd0;
  logic [DATA_W-1:0] wd1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              Mem_Wr;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wr_D;
  logic [DATA_W-1:0] Mem_Rd_D;
  arb_state_t        dbg_state;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, Mem_Rd_D,
    output done0, done1, rdata, busy, Mem_Wr, Mem_Addr, Mem_Wr_D, dbg_state
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wd0, wd1, Mem_Rd_D,
    input  done0, done1, rdata, busy, Mem_Wr, Mem_Addr, Mem_Wr_D, dbg_state
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// The priority bit is owned and updated by the caller.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic sel,
  output logic any
);

  assign any = req0 | req1;

  always_comb begin
    sel = PORT_FETCH;
    if (req0 && req1) sel = prio;
    else if (req1)    sel = PORT_LS;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch (port 0) and load/store (port 1) accesses onto the single memory port.
// Each access runs IDLE -> GRANT -> DONE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input logic                Clk,
  input logic                Rst,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t        state;
  logic              prio;
  logic              sel;
  logic              pick;
  logic              any;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wd;
  logic [DATA_W-1:0] rdata_q;

  rr_arb2 u_rr_arb2 (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .prio (prio),
    .sel  (pick),
    .any  (any)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      sel      <= 1'b0;
      cmd_we   <= 1'b0;
      cmd_addr <= '0;
      cmd_wd   <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            sel      <= pick;
            prio     <= ~pick;
            cmd_we   <= pick ? bus.we1   : bus.we0;
            cmd_addr <= pick ? bus.addr1 : bus.addr0;
            cmd_wd   <= pick ? bus.wd1   : bus.wd0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!cmd_we) rdata_q <= bus.Mem_Rd_D;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory pins come only from registered command state; Rst can still veto a write mid-GRANT.
  assign bus.Mem_Wr    = (state == GRANT) && cmd_we && !Rst;
  assign bus.Mem_Addr  = cmd_addr;
  assign bus.Mem_Wr_D  = cmd_wd;
  assign bus.done0     = (state == DONE) && (sel == PORT_FETCH);
  assign bus.done1     = (state == DONE) && (sel == PORT_LS);
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then randomized traffic
// checked against a transaction-level model of arbitration order and memory contents.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  mem_port_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Memory instance behind the arbiter: sync write, combinational read.
  logic [3:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
  always @(posedge Clk) if (bus.Mem_Wr) mem[bus.Mem_Addr] <= bus.Mem_Wr_D;
  assign bus.Mem_Rd_D = mem[bus.Mem_Addr];

  // ---------------- reference model / scoreboard ----------------
  logic [3:0] ref_mem [16];
  logic       model_prio;
  logic [3:0] last_rdata;
  logic [3:0] seen_rdata;
  logic [4:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    model_prio = 1'b0;
    last_rdata = 4'h0;
    exp_q.delete();
  endtask

  task automatic rand_port(input int p);
    if (p == 0) begin
      bus.req0  = 1'($urandom_range(0, 1));
      bus.we0   = 1'($urandom_range(0, 1));
      bus.addr0 = 4'($urandom_range(0, 15));
      bus.wd0   = 4'($urandom_range(0, 15));
    end else begin
      bus.req1  = 1'($urandom_range(0, 1));
      bus.we1   = 1'($urandom_range(0, 1));
      bus.addr1 = 4'($urandom_range(0, 15));
      bus.wd1   = 4'($urandom_range(0, 15));
    end
  endtask

  // Called during an IDLE cycle with at least one req high; returns in the following IDLE cycle.
  task automatic run_access(input bit perturb, output int served);
    logic       w;
    logic       w_we;
    logic [3:0] w_addr;
    logic [3:0] w_wd;
    logic [3:0] exp_rd;
    logic [4:0] e;
    if (bus.req0 && bus.req1) w = model_prio;
    else                      w = bus.req1;
    model_prio = ~w;
    w_we   = w ? bus.we1   : bus.we0;
    w_addr = w ? bus.addr1 : bus.addr0;
    w_wd   = w ? bus.wd1   : bus.wd0;
    exp_rd = w_we ? last_rdata : ref_mem[w_addr];
    exp_q.push_back({w, exp_rd});
    served = int'(w);

    step();  // GRANT
    check_eq("grant_busy", bus.busy, 1'b1);
    check_eq("grant_mem_wr", bus.Mem_Wr, w_we);
    check_eq("grant_mem_addr", bus.Mem_Addr, w_addr);
    check_eq("grant_mem_wd", bus.Mem_Wr_D, w_wd);
    check_eq("grant_no_done", {bus.done0, bus.done1}, 2'b00);
    if (perturb) begin
      if (!bus.req0) rand_port(0);
      if (!bus.req1) rand_port(1);
    end

    step();  // DONE
    if (w_we) ref_mem[w_addr] = w_wd;
    else      last_rdata = exp_rd;
    e = exp_q.pop_front();
    check_eq("done0", bus.done0, e[4] == 1'b0);
    check_eq("done1", bus.done1, e[4] == 1'b1);
    check_eq("done_rdata", bus.rdata, e[3:0]);
    check_eq("done_mem_wr", bus.Mem_Wr, 1'b0);
    check_eq("done_mem_addr", bus.Mem_Addr, w_addr);
    seen_rdata = bus.rdata;
    if (perturb) begin
      if (!w || !bus.req0) rand_port(0);
      if (w  || !bus.req1) rand_port(1);
    end

    step();  // IDLE
    check_eq("idle_busy", bus.busy, 1'b0);
    check_eq("idle_no_done", {bus.done0, bus.done1}, 2'b00);
    check_eq("idle_mem_wr", bus.Mem_Wr, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
    Rst = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wd0 = 0; bus.wd1 = 0;
    model_prio = 1'b0;
    last_rdata = 4'h0;
    seen_rdata = 4'h0;
    step();
    step();
    check_eq("rst_done", {bus.done0, bus.done1}, 2'b00);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_mem_wr", bus.Mem_Wr, 1'b0);
    check_eq("rst_mem_addr", bus.Mem_Addr, 4'h0);
    check_eq("rst_mem_wd", bus.Mem_Wr_D, 4'h0);
    check_eq("rst_rdata", bus.rdata, 4'h0);
    Rst = 1'b0;

    // Port 1 writes A to addr 3, then port 0 reads it back.
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'h3; bus.wd1 = 4'hA;
    run_access(1'b0, s);
    check_eq("t1_served", s, 1);
    bus.req1 = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'h3;
    run_access(1'b0, s);
    check_eq("t2_served", s, 0);
    check_eq("t2_rdata", seen_rdata, 4'hA);
    bus.req0 = 0;

    // Both requesting continuously from reset: alternate 0,1,0,1.
    apply_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'h3;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'h1;
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, s);
      check_eq("t3_order", s, i % 2);
    end

    // Port 1 alone twice, then a tie goes to port 0.
    apply_reset();
    bus.req0 = 0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'h3;
    run_access(1'b0, s);
    check_eq("t4_first", s, 1);
    run_access(1'b0, s);
    check_eq("t4_second", s, 1);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'h2;
    run_access(1'b0, s);
    check_eq("t4_tie", s, 0);

    // Reset during the GRANT of a write of 5 to addr 7.
    apply_reset();
    bus.req0 = 0;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'h7; bus.wd1 = 4'h5;
    step();
    check_eq("t5_pre_rst_wr", bus.Mem_Wr, 1'b1);
    Rst = 1'b1;
    #1;
    check_eq("t5_rst_wr", bus.Mem_Wr, 1'b0);
    step();
    Rst = 1'b0;
    bus.req1 = 0;
    check_eq("t5_no_done_a", {bus.done0, bus.done1}, 2'b00);
    check_eq("t5_idle", bus.busy, 1'b0);
    step();
    check_eq("t5_no_done_b", {bus.done0, bus.done1}, 2'b00);
    model_prio = 1'b0;
    last_rdata = 4'h0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'h7;
    run_access(1'b0, s);
    check_eq("t5_rd7", seen_rdata, 4'h0);
    bus.req0 = 0;

    // addr0 changed while busy: latched address holds, re-request uses the new one.
    apply_reset();
    bus.req1 = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'h3;
    step();
    bus.addr0 = 4'h5;
    #1;
    check_eq("t6_grant_addr", bus.Mem_Addr, 4'h3);
    step();
    check_eq("t6_done0", bus.done0, 1'b1);
    check_eq("t6_done_addr", bus.Mem_Addr, 4'h3);
    check_eq("t6_rdata", bus.rdata, ref_mem[3]);
    step();
    check_eq("t6_idle", bus.busy, 1'b0);
    step();
    check_eq("t6_new_busy", bus.busy, 1'b1);
    check_eq("t6_new_addr", bus.Mem_Addr, 4'h5);
    step();
    check_eq("t6_new_done0", bus.done0, 1'b1);
    check_eq("t6_new_rdata", bus.rdata, ref_mem[5]);
    bus.req0 = 0;
    step();
    apply_reset();

    // Randomized traffic with idle gaps and perturbation of non-requesting ports.
    rand_port(0);
    rand_port(1);
    for (int it = 0; it < 250; it++) begin
      if (!bus.req0 && !bus.req1 && $urandom_range(0, 3) == 0) begin
        step();
        check_eq("rand_idle_busy", bus.busy, 1'b0);
        check_eq("rand_idle_done", {bus.done0, bus.done1}, 2'b00);
        rand_port(0);
        rand_port(1);
      end else begin
        if (!bus.req0 && !bus.req1) begin
          if ($urandom_range(0, 1) == 0) bus.req0 = 1;
          else                           bus.req1 = 1;
        end
        run_access(1'b1, s);
      end
    end

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
